// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, data widths and the result-stage entry payload.
package alu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] result;
        alu_flags_t        flags;
    } alu_entry_t;

    // Only the adder ops produce meaningful carry/overflow.
    function automatic logic is_arith(logic [OP_W-1:0] op);
        return (op == OP_W'(ALU_ADD)) || (op == OP_W'(ALU_SUB));
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Producer/consumer handshake bundle around the ALU result stage.
interface alu_result_stage_if;

    logic                       in_valid;
    logic                       in_ready;
    logic [alu_pkg::OP_W-1:0]   in_op;
    logic [alu_pkg::DATA_W-1:0] in_result;
    logic                       in_carryout;
    logic                       in_overflow;

    logic                       out_valid;
    logic                       out_ready;
    logic [alu_pkg::OP_W-1:0]   out_op;
    logic [alu_pkg::DATA_W-1:0] out_result;
    logic                       out_zero;
    logic                       out_negative;
    logic                       out_carry;
    logic                       out_overflow;

    modport slave (
        input  in_valid, in_op, in_result, in_carryout, in_overflow, out_ready,
        output in_ready, out_valid, out_op, out_result,
               out_zero, out_negative, out_carry, out_overflow
    );

    modport master (
        output in_valid, in_op, in_result, in_carryout, in_overflow, out_ready,
        input  in_ready, out_valid, out_op, out_result,
               out_zero, out_negative, out_carry, out_overflow
    );

endinterface

// File: rtl/alu_result_fifo.sv
// Generic DEPTH x WIDTH FIFO (DEPTH a power of two, >= 2) with registered head output.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];

    // Guarded so a push into a full or pop from an empty FIFO is a no-op.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag derivation, FIFO buffering and optional stats.
// Optional feature macro: ALU_RESULT_STATS_EN (accepted-result counter and overflow sticky).
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned STATS_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    alu_result_stage_if.slave  bus,
    input  logic               stat_clear,
    output logic [STATS_W-1:0] stat_count,
    output logic               stat_ovf_sticky
);

    alu_entry_t entry_d;
    alu_entry_t head;
    logic       full, empty;
    logic       push, pop;

    // Normalise the mux output and compute flags on the value actually stored.
    always_comb begin
        entry_d        = '0;
        entry_d.op     = bus.in_op;
        entry_d.result = (bus.in_op == OP_W'(ALU_SLT))
                       ? {{(DATA_W-1){1'b0}}, bus.in_result[0]}
                       : bus.in_result;
        entry_d.flags.zero     = (entry_d.result == '0);
        entry_d.flags.negative = entry_d.result[DATA_W-1];
        if (is_arith(bus.in_op)) begin
            entry_d.flags.carry    = bus.in_carryout;
            entry_d.flags.overflow = bus.in_overflow;
        end
    end

    // Ready depends only on stored occupancy (and reset), never on out_ready.
    assign bus.in_ready  = ~reset & ~full;
    assign bus.out_valid = ~empty;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(alu_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (entry_d),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.out_op       = head.op;
    assign bus.out_result   = head.result;
    assign bus.out_zero     = head.flags.zero;
    assign bus.out_negative = head.flags.negative;
    assign bus.out_carry    = head.flags.carry;
    assign bus.out_overflow = head.flags.overflow;

`ifdef ALU_RESULT_STATS_EN
    logic [STATS_W-1:0] stat_count_q, stat_count_d;
    logic               ovf_sticky_q, ovf_sticky_d;

    // Clear has priority over a same-cycle push.
    always_comb begin
        stat_count_d = stat_count_q;
        ovf_sticky_d = ovf_sticky_q;
        if (stat_clear) begin
            stat_count_d = '0;
            ovf_sticky_d = 1'b0;
        end else if (push) begin
            stat_count_d = stat_count_q + STATS_W'(1);
            if (is_arith(bus.in_op) && bus.in_overflow) ovf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_count_q <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            stat_count_q <= stat_count_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign stat_count      = stat_count_q;
    assign stat_ovf_sticky = ovf_sticky_q;
`else
    logic unused_stat_clear;
    assign unused_stat_clear = stat_clear;
    assign stat_count        = '0;
    assign stat_ovf_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (DEPTH=2), stats-aware via ALU_RESULT_STATS_EN.
module tb_alu_result_stage;

`ifdef ALU_RESULT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stat_clear;
    logic [15:0] stat_count;
    logic        stat_ovf_sticky;
    int          n_assert = 0;
    int          n_fail   = 0;

    alu_result_stage_if bus ();

    alu_result_stage #(.DEPTH(2), .STATS_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .stat_clear      (stat_clear),
        .stat_count      (stat_count),
        .stat_ovf_sticky (stat_ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] res, input logic c, input logic o);
        bus.in_valid    = 1'b1;
        bus.in_op       = op;
        bus.in_result   = res;
        bus.in_carryout = c;
        bus.in_overflow = o;
    endtask

    task automatic push_one(input logic [2:0] op, input logic [31:0] res, input logic c, input logic o);
        drive(op, res, c, o);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [2:0] op, input logic [31:0] res,
                            input logic z, input logic n, input logic c, input logic o);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".op"},    32'(bus.out_op), 32'(op));
        chk({tag, ".res"},   bus.out_result, res);
        chk({tag, ".flags"}, 32'({bus.out_zero, bus.out_negative, bus.out_carry, bus.out_overflow}),
            32'({z, n, c, o}));
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        stat_clear      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_op       = '0;
        bus.in_result   = '0;
        bus.in_carryout = 1'b0;
        bus.in_overflow = 1'b0;
        bus.out_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst.in_ready_during", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst.in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out_op", 32'(bus.out_op), 32'd0);
        chk("rst.out_result", bus.out_result, 32'd0);
        chk("rst.flags", 32'({bus.out_zero, bus.out_negative, bus.out_carry, bus.out_overflow}), 32'd0);
        chk("rst.stat_count", 32'(stat_count), 32'd0);
        chk("rst.sticky", 32'(stat_ovf_sticky), 32'd0);

        // ADD 0xFFFFFFFF+1: zero result with carry; no bypass, appears next cycle
        drive(3'd0, 32'h0000_0000, 1'b1, 1'b0);
        #1;
        chk("add.no_bypass", 32'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk_head("add", 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_head("add.stable", 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        pop_one();
        chk("add.popped", 32'(bus.out_valid), 32'd0);

        // SLT keeps only bit 0; carry/overflow forced low
        push_one(3'd3, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk_head("slt", 3'd3, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_one();

        // Logic op with negative result; carry/overflow forced low
        push_one(3'd2, 32'h8000_0000, 1'b1, 1'b1);
        chk_head("xor", 3'd2, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        pop_one();

        // SUB passes carry/overflow through
        push_one(3'd1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        chk_head("sub", 3'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        pop_one();

        // Back-pressure: third entry held off while full
        drive(3'd4, 32'd1, 1'b0, 1'b0);
        tick();
        chk("full.rdy1", 32'(bus.in_ready), 32'd1);
        drive(3'd7, 32'd2, 1'b0, 1'b0);
        tick();
        chk("full.rdy2", 32'(bus.in_ready), 32'd0);
        drive(3'd2, 32'd3, 1'b0, 1'b0);
        tick();
        chk("full.held_rdy", 32'(bus.in_ready), 32'd0);
        chk_head("full.head1", 3'd4, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk_head("full.head2", 3'd7, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk_head("full.head3", 3'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        chk("full.drained", 32'(bus.out_valid), 32'd0);

        // Streaming: one-cycle latency, occupancy never above 1
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(3'd0, 32'(100 + i), 1'b0, 1'b0);
            tick();
            chk("stream.res", bus.out_result, 32'(100 + i));
            chk("stream.valid", 32'(bus.out_valid), 32'd1);
            chk("stream.rdy", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        chk("stream.empty", 32'(bus.out_valid), 32'd0);

        // Reset mid-stream with two entries queued
        push_one(3'd7, 32'h55, 1'b0, 1'b0);
        push_one(3'd7, 32'h66, 1'b0, 1'b0);
        chk("mrst.full", 32'(bus.in_ready), 32'd0);
        chk("mrst.count_before", 32'(stat_count), STATS ? 32'd19 : 32'd0);
        chk("mrst.sticky_before", 32'(stat_ovf_sticky), STATS ? 32'd1 : 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mrst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("mrst.stat_count", 32'(stat_count), 32'd0);
        chk("mrst.sticky", 32'(stat_ovf_sticky), 32'd0);

        // Stats: five accepted pushes, one SUB overflow
        bus.out_ready = 1'b1;
        push_one(3'd0, 32'd10, 1'b0, 1'b0);
        push_one(3'd1, 32'd11, 1'b0, 1'b1);
        push_one(3'd2, 32'd12, 1'b0, 1'b0);
        push_one(3'd7, 32'd13, 1'b0, 1'b0);
        push_one(3'd4, 32'd14, 1'b0, 1'b0);
        tick();
        chk("stats.count5", 32'(stat_count), STATS ? 32'd5 : 32'd0);
        chk("stats.sticky", 32'(stat_ovf_sticky), STATS ? 32'd1 : 32'd0);
        stat_clear = 1'b1;
        push_one(3'd1, 32'd15, 1'b0, 1'b1);
        stat_clear = 1'b0;
        chk("stats.clear_count", 32'(stat_count), 32'd0);
        chk("stats.clear_sticky", 32'(stat_ovf_sticky), 32'd0);
        chk("stats.clear_push_data", bus.out_result, 32'd15);
        push_one(3'd0, 32'd16, 1'b0, 1'b0);
        chk("stats.count1", 32'(stat_count), STATS ? 32'd1 : 32'd0);
        tick();
        bus.out_ready = 1'b0;
        chk("stats.empty", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
